// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared types and timing derivations.
// Optional timeout is enabled with PS2_TX_TIMEOUT_EN.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAITIDLE
    } state_t;

    // 100 us clock inhibit, rounded up
    function automatic int unsigned inh_cycles(input int unsigned hz);
        return (hz + 32'd9999) / 32'd10000;
    endfunction

    // 15 ms whole-transfer limit
    function automatic int unsigned tmo_cycles(input int unsigned hz);
        logic [63:0] t;
        t = 64'(hz) * 64'd15 / 64'd1000;
        return t[31:0];
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop pad synchroniser with falling-edge detect.
// One instance per PS/2 line.
module ps2_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pad,
    output logic o_sync,
    output logic o_fall
);

    logic [2:0] r_sh;

    // Idle PS/2 lines are high, so reset to 1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sh <= 3'b111;
        else          r_sh <= {r_sh[1:0], i_pad};
    end

    assign o_sync = r_sh[1];
    assign o_fall = r_sh[2] & ~r_sh[1];

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request, 11-bit frame, ack).
// Define PS2_TX_TIMEOUT_EN to abort transfers that stall beyond 15 ms.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLKHZ = 28000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       strobe,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2CkI,
    output logic       ps2CkO,
    input  logic       ps2DtI,
    output logic       ps2DtO
);

    localparam int unsigned INH = inh_cycles(CLKHZ);
    localparam logic [31:0] INH_LAST = 32'(INH - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_data;
    logic        r_par;
    logic [3:0]  r_bits;
    logic [31:0] r_cnt;
    logic        r_done;
    logic        r_error;

    logic w_ck, w_ckf, w_dt, w_dtf;
    logic w_accept, w_inh_end, w_idle, w_nak, w_tmo, w_bit;

    ps2_sync u_sync_ck (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_pad   (ps2CkI),
        .o_sync  (w_ck),
        .o_fall  (w_ckf)
    );

    ps2_sync u_sync_dt (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_pad   (ps2DtI),
        .o_sync  (w_dt),
        .o_fall  (w_dtf)
    );

    assign w_accept  = (r_state == IDLE) & strobe & ~r_done & ~r_error;
    assign w_inh_end = (r_state == INHIBIT) && (r_cnt == INH_LAST);
    assign w_idle    = w_ck & w_dt & ~w_ckf & ~w_dtf;
    assign w_nak     = (r_state == ACK) & w_ckf & w_dt;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TMO = tmo_cycles(CLKHZ);
    localparam logic [31:0] TMO_LAST = 32'(TMO - 1);

    logic [31:0] r_tmo;
    logic        w_active;

    assign w_active = (r_state == REQ) | (r_state == SEND) |
                      (r_state == ACK) | (r_state == WAITIDLE);
    assign w_tmo    = w_active && (r_tmo == TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                r_tmo <= '0;
        else if (w_active && !w_tmo) r_tmo <= r_tmo + 32'd1;
        else                       r_tmo <= '0;
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:     if (w_accept) w_next = INHIBIT;
                INHIBIT:  if (w_inh_end) w_next = REQ;
                REQ:      w_next = SEND;
                SEND:     if (w_ckf && r_bits == 4'd9) w_next = ACK;
                ACK:      if (w_ckf) w_next = w_dt ? IDLE : WAITIDLE;
                WAITIDLE: if (w_idle) w_next = IDLE;
                default:  w_next = IDLE;
            endcase
        end
    end

    // Bit on the wire after r_bits device falling edges
    always_comb begin
        w_bit = 1'b1;
        if (r_bits == 4'd0)      w_bit = 1'b0;
        else if (r_bits <= 4'd8) w_bit = r_data[r_bits[2:0] - 3'd1];
        else if (r_bits == 4'd9) w_bit = r_par;
    end

    always_comb begin
        ps2CkO = 1'b1;
        ps2DtO = 1'b1;
        unique case (r_state)
            INHIBIT: begin
                ps2CkO = 1'b0;
                ps2DtO = ~w_inh_end;
            end
            REQ:     ps2DtO = 1'b0;
            SEND:    ps2DtO = w_bit;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_par   <= 1'b0;
            r_bits  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_done  <= (r_state == WAITIDLE) & w_idle & ~w_tmo;
            r_error <= w_tmo | w_nak;
            if (r_state == INHIBIT) r_cnt <= r_cnt + 32'd1;
            else                    r_cnt <= '0;
            if (w_accept) begin
                r_data <= data;
                r_par  <= ~^data;
                r_bits <= '0;
            end else if (r_state == SEND && w_ckf && r_bits != 4'hF) begin
                r_bits <= r_bits + 4'd1;
            end
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign error = r_error;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with a 12 kHz keyboard model.
// Define PS2_TX_TIMEOUT_EN to exercise the timeout build.
module tb_ps2_tx;

    localparam int unsigned HZ = 1200000;
    localparam int HALF = 50;
    localparam int LIM  = 30000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       strobe = 1'b0;
    logic       strobe28 = 1'b0;
    logic [7:0] data = 8'h00;
    logic [7:0] data28 = 8'h00;
    logic       kb_ck = 1'b1;
    logic       kb_dt = 1'b1;

    logic busy, done, error, ckO, dtO;
    logic busy28, done28, err28, ckO28, dtO28;
    logic ck_line, dt_line;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int n_errp = 0;
    logic prev_busy = 1'b0;
    logic dbad = 1'b0;

    assign ck_line = ckO & kb_ck;
    assign dt_line = dtO & kb_dt;

    ps2_tx #(.CLKHZ(HZ)) u_dut (
        .clock  (clk),
        .reset  (rst_n),
        .strobe (strobe),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .ps2CkI (ck_line),
        .ps2CkO (ckO),
        .ps2DtI (dt_line),
        .ps2DtO (dtO)
    );

    ps2_tx #(.CLKHZ(28000000)) u_dut28 (
        .clock  (clk),
        .reset  (rst_n),
        .strobe (strobe28),
        .data   (data28),
        .busy   (busy28),
        .done   (done28),
        .error  (err28),
        .ps2CkI (1'b1),
        .ps2CkO (ckO28),
        .ps2DtI (1'b1),
        .ps2DtO (dtO28)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done)  n_done <= n_done + 1;
        if (error) n_errp <= n_errp + 1;
        if (done && (busy || !prev_busy || error)) dbad <= 1'b1;
        prev_busy <= busy;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        data = d;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        data = 8'h00;
    endtask

    task automatic measure(output int lo, output int dlo);
        int c = 0;
        lo = 0;
        dlo = 0;
        while (ckO !== 1'b0 && c < LIM) begin @(negedge clk); c++; end
        while (ckO === 1'b0 && c < LIM) begin
            lo++;
            if (dtO === 1'b0) dlo++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic kb_frame(input logic ack, input int stop_at,
                            output logic [10:0] fr, output logic ok);
        int c = 0;
        fr = '1;
        ok = 1'b1;
        while (ckO !== 1'b0 && c < LIM) begin @(negedge clk); c++; end
        while (ckO === 1'b0 && c < LIM) begin @(negedge clk); c++; end
        if (c >= LIM) begin
            ok = 1'b0;
            return;
        end
        repeat (HALF) @(negedge clk);
        fr[0] = dt_line;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) kb_dt = 1'b0;
            kb_ck = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i <= 10) fr[i] = dt_line;
            if (i == stop_at) return;
            kb_ck = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        kb_dt = 1'b1;
    endtask

    initial begin
        logic [10:0] fr;
        logic ok;
        int lo, dlo, c, d0, e0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ck", 32'(ckO), 1);
        chk("rst_dt", 32'(dtO), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(error), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ED frame with a stray F4 strobe mid-frame
        d0 = n_done;
        e0 = n_errp;
        send(8'hED);
        fork
            measure(lo, dlo);
            kb_frame(1'b1, 0, fr, ok);
            begin
                repeat (500) @(negedge clk);
                data = 8'hF4;
                strobe = 1'b1;
                @(negedge clk);
                strobe = 1'b0;
                data = 8'h00;
            end
        join
        repeat (20) @(negedge clk);
        chk("inh_len", lo, 120);
        chk("inh_dt", dlo, 1);
        chk("ed_ok", 32'(ok), 1);
        chk("ed_frame", 32'(fr), 32'h7DA);
        chk("ed_done", n_done - d0, 1);
        chk("ed_err", n_errp - e0, 0);
        chk("ed_busy", 32'(busy), 0);
        chk("done_busy", 32'(dbad), 0);

        // 28 MHz instance inhibit length
        @(negedge clk);
        data28 = 8'hED;
        strobe28 = 1'b1;
        @(negedge clk);
        strobe28 = 1'b0;
        lo = 0;
        dlo = 0;
        c = 0;
        while (ckO28 === 1'b0 && c < LIM) begin
            lo++;
            if (dtO28 === 1'b0) dlo++;
            c++;
            @(negedge clk);
        end
        chk("inh28_len", lo, 2800);
        chk("inh28_dt", dlo, 1);

        // No acknowledge
        d0 = n_done;
        e0 = n_errp;
        send(8'h55);
        kb_frame(1'b0, 0, fr, ok);
        repeat (20) @(negedge clk);
        chk("nak_frame", 32'(fr), 32'h6AA);
        chk("nak_err", n_errp - e0, 1);
        chk("nak_done", n_done - d0, 0);
        chk("nak_ck", 32'(ckO), 1);
        chk("nak_dt", 32'(dtO), 1);
        chk("nak_busy", 32'(busy), 0);

        // Asynchronous reset at device edge 5
        send(8'hED);
        kb_frame(1'b1, 5, fr, ok);
        chk("mid_dt_pre", 32'(dtO), 0);
        chk("mid_busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_ck", 32'(ckO), 1);
        chk("mid_dt", 32'(dtO), 1);
        chk("mid_busy", 32'(busy), 0);
        kb_ck = 1'b1;
        kb_dt = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // First strobe after reset
        d0 = n_done;
        send(8'hF4);
        kb_frame(1'b1, 0, fr, ok);
        repeat (20) @(negedge clk);
        chk("f4_frame", 32'(fr), 32'h5E8);
        chk("f4_done", n_done - d0, 1);

        // Keyboard never clocks
        e0 = n_errp;
        send(8'h12);
        c = 0;
        while (ckO === 1'b0 && c < LIM) begin @(negedge clk); c++; end
        chk("req_seen", 32'(ckO), 1);
        c = 0;
`ifdef PS2_TX_TIMEOUT_EN
        while (!error && c < 20000) begin @(negedge clk); c++; end
        chk("tmo_cycles", c, 18000);
        chk("tmo_ck", 32'(ckO), 1);
        chk("tmo_dt", 32'(dtO), 1);
        chk("tmo_busy", 32'(busy), 0);
`else
        repeat (20000) @(negedge clk);
        chk("tmo_busy", 32'(busy), 1);
        chk("tmo_err", n_errp - e0, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter CLKHZ, default 28000000, system clock frequency in Hz, used to derive all timing.
REQ-002 SHALL have port clock, input, 1, system clock (clock28 at top level); all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port strobe, input, 1, one-cycle request to send data.
REQ-005 SHALL have port data, input, 8, byte to send to the keyboard, e.g. ED = set LEDs.
REQ-006 SHALL have port busy, output, 1, high from accepted strobe until done or error.
REQ-007 SHALL have port done, output, 1, one-cycle pulse: frame acknowledged and bus idle.
REQ-008 SHALL have port error, output, 1, one-cycle pulse: no ack or timeout.
REQ-009 SHALL have port ps2CkI, input, 1, PS/2 clock line as read from the pad.
REQ-010 SHALL have port ps2CkO, output, 1, PS/2 clock drive; 0 = pull low, 1 = release (open-drain at top level).
REQ-011 SHALL have port ps2DtI, input, 1, PS/2 data line as read from the pad.
REQ-012 SHALL have port ps2DtO, output, 1, PS/2 data drive; 0 = pull low, 1 = release.

Function
REQ-013 SHALL pass ps2CkI and ps2DtI through 2-flop synchronisers; a falling clock edge is a synchronised 1->0 transition.
REQ-014 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAITIDLE.
REQ-015 IDLE: strobe latches data, computes odd parity, sets busy, and enters INHIBIT on the next cycle.
REQ-016 INHIBIT: SHALL hold ps2CkO=0 for exactly INH=ceil(CLKHZ/10000) cycles (100 us), with ps2DtO=0 asserted in the last INHIBIT cycle, then enter REQ.
REQ-017 REQ: SHALL release the clock (ps2CkO=1) with ps2DtO=0 held as the start bit, then enter SEND.
REQ-018 SEND: on falling edges 1..8, SHALL set ps2DtO to data[0]..data[7]; on edge 9, to parity; on edge 10, release it (stop bit, 1); then enter ACK.
REQ-019 ACK: at falling edge 11, SHALL sample synchronised data; 0 means acknowledged and enters WAITIDLE, 1 pulses error and returns to IDLE.
REQ-020 WAITIDLE: when synchronised clock and data are both 1, SHALL pulse done, clear busy and return to IDLE.
REQ-021 Outside INHIBIT/REQ/SEND, SHALL hold ps2CkO=1 and ps2DtO=1 (both lines released).
REQ-022 strobe while busy SHALL be ignored; data is captured only at acceptance.
REQ-023 done and error SHALL be mutually exclusive and never asserted in the same cycle as strobe acceptance.
REQ-024 Bit counter SHALL be 4 bits and saturate; spurious edges in WAITIDLE SHALL be ignored.

Reset
REQ-025 reset low SHALL immediately force IDLE, busy=0, done=0, error=0, ps2CkO=1, ps2DtO=1, counters=0, including mid-frame.
REQ-026 After reset release, the first strobe SHALL be accepted normally; no pending request survives reset.

Configuration
REQ-027 With PS2_TX_TIMEOUT_EN defined, SHALL abort to IDLE with an error pulse and both lines released if any state from REQ to WAITIDLE lasts more than TMO=CLKHZ*15/1000 cycles (15 ms) in total.
REQ-028 Without PS2_TX_TIMEOUT_EN, SHALL wait indefinitely in REQ to WAITIDLE; no timeout counter is synthesised.

Structure
REQ-029 Package ps2_pkg SHALL hold the state enum and the INH/TMO derivation functions.
REQ-030 Sub-module ps2_sync (2-flop synchroniser plus falling-edge detect) SHALL be instantiated once per line.

Verification
REQ-031 data=ED, keyboard model clocks at 12 kHz and acks -> line shows start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; then one done pulse; busy falls in the same cycle as done.
REQ-032 CLKHZ=28000000 -> ps2CkO low for exactly 2800 cycles after strobe acceptance.
REQ-033 Model gives no ack (data high at edge 11) -> error pulse, no done, lines released.
REQ-034 Second strobe with data=F4 during the ED frame -> ignored; frame carries ED only.
REQ-035 reset asserted at edge 5 -> ps2CkO=1, ps2DtO=1, busy=0 without waiting for a clock edge.
REQ-036 PS2_TX_TIMEOUT_EN defined, model never clocks -> error 420000 cycles after entering REQ; macro undefined -> busy stays 1.
